// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
// Machine-mode CSR file with interrupt trap entry and MRET return for a
// single-issue pipeline. Holds mstatus, mie, mtvec, mepc, mcause and mip.
// A two-state FSM (IDLE / REDIRECT) raises 'interrupt' while a trap is being
// taken. It then produces a one-cycle 'epc_taken' pulse with the redirect
// target on 'epc'.
//
// Build option:
//   CSR_VECTORED_EN  defined   -> mtvec[1:0] writable; MODE=1 vectors traps
//                                 to base + 4*cause code.
//                    undefined -> mtvec[1:0] hardwired to 0, direct mode only.
// ---------------------------------------------------------------------------
module csr_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        is_mret,
    input  logic [31:0] pc_ex,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        interrupt,
    output logic        epc_taken,
    output logic [31:0] epc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

`ifdef CSR_VECTORED_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_mstatusMie;
    logic        r_mstatusMpie;
    logic        r_mieMtie;
    logic        r_mieMeie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mipMtip;
    logic        r_mipMeip;
    logic [31:0] r_epc;

    logic [31:0] w_mstatus;
    logic [31:0] w_mie;
    logic [31:0] w_mip;
    logic [31:0] w_csrNew;
    logic        w_extPending;
    logic        w_timerPending;
    logic        w_pending;
    logic [3:0]  w_code;
    logic [31:0] w_vecBase;
    logic [31:0] w_trapVector;
    logic        w_doTrap;
    logic        w_doMret;
    logic        w_csrWe;

    assign w_mstatus = {24'b0, r_mstatusMpie, 3'b0, r_mstatusMie, 3'b0};
    assign w_mie     = {20'b0, r_mieMeie, 3'b0, r_mieMtie, 7'b0};
    assign w_mip     = {20'b0, r_mipMeip, 3'b0, r_mipMtip, 7'b0};

    assign w_extPending   = r_mipMeip & r_mieMeie;
    assign w_timerPending = r_mipMtip & r_mieMtie;
    assign w_pending      = r_mstatusMie & (w_extPending | w_timerPending);
    assign w_code         = w_extPending ? 4'd11 : 4'd7;
    assign w_vecBase      = {r_mtvec[31:2], 2'b00};

`ifdef CSR_VECTORED_EN
    assign w_trapVector = (r_mtvec[1:0] == 2'b01) ? (w_vecBase + {26'b0, w_code, 2'b00})
                                                 : w_vecBase;
`else
    assign w_trapVector = w_vecBase;
`endif

    assign epc = r_epc;

    // Read mux: unimplemented addresses return zero.
    always_comb begin
        csr_rdata = 32'b0;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = w_mstatus;
            ADDR_MIE:     csr_rdata = w_mie;
            ADDR_MTVEC:   csr_rdata = r_mtvec;
            ADDR_MEPC:    csr_rdata = r_mepc;
            ADDR_MCAUSE:  csr_rdata = r_mcause;
            ADDR_MIP:     csr_rdata = w_mip;
            default:      csr_rdata = 32'b0;
        endcase
    end

    // Read-modify-write value; write masks are applied per register at commit.
    always_comb begin
        w_csrNew = csr_rdata;
        case (csr_op)
            OP_WRITE: w_csrNew = csr_wdata;
            OP_SET:   w_csrNew = csr_rdata | csr_wdata;
            OP_CLEAR: w_csrNew = csr_rdata & ~csr_wdata;
            default:  w_csrNew = csr_rdata;
        endcase
    end

    // Next-state and trap/return decode; a trap flushes the EX instruction.
    always_comb begin
        w_nextState = r_state;
        interrupt   = 1'b0;
        epc_taken   = 1'b0;
        w_doTrap    = 1'b0;
        w_doMret    = 1'b0;
        w_csrWe     = 1'b0;
        case (r_state)
            IDLE: begin
                interrupt = w_pending;
                w_csrWe   = (csr_op != OP_NONE) && !w_pending;
                if (w_pending) begin
                    w_doTrap    = 1'b1;
                    w_nextState = REDIRECT;
                end else if (is_mret) begin
                    w_doMret    = 1'b1;
                    w_nextState = REDIRECT;
                end
            end
            REDIRECT: begin
                epc_taken   = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Interrupt lines are registered once into mip.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mipMtip <= 1'b0;
            r_mipMeip <= 1'b0;
        end else begin
            r_mipMtip <= timer_irq;
            r_mipMeip <= ext_irq;
        end
    end

    // CSR commit, trap entry and MRET return; MRET's mstatus update overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatusMie  <= 1'b0;
            r_mstatusMpie <= 1'b0;
            r_mieMtie     <= 1'b0;
            r_mieMeie     <= 1'b0;
            r_mtvec       <= 32'b0;
            r_mepc        <= 32'b0;
            r_mcause      <= 32'b0;
            r_epc         <= 32'b0;
        end else begin
            if (w_csrWe) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        r_mstatusMie  <= w_csrNew[3];
                        r_mstatusMpie <= w_csrNew[7];
                    end
                    ADDR_MIE: begin
                        r_mieMtie <= w_csrNew[7];
                        r_mieMeie <= w_csrNew[11];
                    end
                    ADDR_MTVEC:  r_mtvec  <= w_csrNew & MTVEC_MASK;
                    ADDR_MEPC:   r_mepc   <= {w_csrNew[31:2], 2'b00};
                    ADDR_MCAUSE: r_mcause <= w_csrNew;
                    default: ;
                endcase
            end
            if (w_doTrap) begin
                r_mepc        <= {pc_ex[31:2], 2'b00};
                r_mcause      <= {1'b1, 27'b0, w_code};
                r_mstatusMpie <= r_mstatusMie;
                r_mstatusMie  <= 1'b0;
                r_epc         <= w_trapVector;
            end else if (w_doMret) begin
                r_mstatusMie  <= r_mstatusMpie;
                r_mstatusMpie <= 1'b1;
                r_epc         <= r_mepc;
            end
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
// Self-checking bench for csr_unit: directed trap/MRET scenarios plus
// randomized traffic compared against a word-level reference model.
// Honours CSR_VECTORED_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        is_mret;
    logic [31:0] pc_ex;
    logic        timer_irq;
    logic        ext_irq;
    logic [31:0] csr_rdata;
    logic        interrupt;
    logic        epc_taken;
    logic [31:0] epc;

    int compared   = 0;
    int mismatched = 0;

`ifdef CSR_VECTORED_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    logic [11:0] addrList [0:6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h340};

    // Reference model state, as whole 32-bit CSR words.
    logic [31:0] refMstatus, refMie, refMtvec, refMepc, refMcause, refMip, refEpc;
    bit          refRedirect;

    always #5 clk = ~clk;

    csr_unit dut (
        .clk       (clk),
        .rst       (rst),
        .csr_addr  (csr_addr),
        .csr_op    (csr_op),
        .csr_wdata (csr_wdata),
        .is_mret   (is_mret),
        .pc_ex     (pc_ex),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .csr_rdata (csr_rdata),
        .interrupt (interrupt),
        .epc_taken (epc_taken),
        .epc       (epc)
    );

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        case (a)
            12'h300: return refMstatus;
            12'h304: return refMie;
            12'h305: return refMtvec;
            12'h341: return refMepc;
            12'h342: return refMcause;
            12'h344: return refMip;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit modelPending();
        return refMstatus[3] && ((refMip[11] && refMie[11]) || (refMip[7] && refMie[7]));
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelAdvance();
        logic [31:0] oldVal, newVal, oldStatus, oldMepc, base, nextMip;
        int code;
        nextMip = 32'h0;
        nextMip[11] = ext_irq;
        nextMip[7]  = timer_irq;
        if (rst) begin
            refMstatus = 0; refMie = 0; refMtvec = 0; refMepc = 0;
            refMcause = 0; refMip = 0; refEpc = 0; refRedirect = 0;
            return;
        end
        if (refRedirect) begin
            refRedirect = 0;
        end else if (modelPending()) begin
            code = (refMip[11] && refMie[11]) ? 11 : 7;
            base = refMtvec & 32'hFFFF_FFFC;
            refEpc = (refMtvec[1:0] == 2'b01) ? base + 32'(4 * code) : base;
            refMepc = pc_ex & 32'hFFFF_FFFC;
            refMcause = 32'h8000_0000 + 32'(code);
            refMstatus = refMstatus[3] ? 32'h80 : 32'h0;
            refRedirect = 1;
        end else begin
            oldStatus = refMstatus;
            oldMepc = refMepc;
            if (csr_op != 2'b00) begin
                oldVal = modelRead(csr_addr);
                newVal = (csr_op == 2'b01) ? csr_wdata :
                         (csr_op == 2'b10) ? (oldVal | csr_wdata) : (oldVal & ~csr_wdata);
                case (csr_addr)
                    12'h300: refMstatus = newVal & 32'h88;
                    12'h304: refMie     = newVal & 32'h880;
                    12'h305: refMtvec   = newVal & MTVEC_MASK;
                    12'h341: refMepc    = newVal & 32'hFFFF_FFFC;
                    12'h342: refMcause  = newVal;
                    default: ;
                endcase
            end
            if (is_mret) begin
                refMstatus = 32'h80 | (oldStatus[7] ? 32'h8 : 32'h0);
                refEpc = oldMepc;
                refRedirect = 1;
            end
        end
        refMip = nextMip;
    endtask

    task automatic tick();
        @(posedge clk);
        modelAdvance();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        csr_addr = 12'h0; csr_op = 2'b00; csr_wdata = 32'h0; is_mret = 1'b0;
        pc_ex = 32'h0; timer_irq = 1'b0; ext_irq = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic csrWrite(input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_op = 2'b01; csr_wdata = d;
        tick();
        csr_op = 2'b00; csr_wdata = 32'h0;
    endtask

    task automatic test_reset();
        doReset();
        #1;
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_interrupt: got %0b want 0", interrupt); end
        compared++; if (epc_taken !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_epc_taken: got %0b want 0", epc_taken); end
        compared++; if (epc !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_epc: got %h want 0", epc); end
        for (int i = 0; i < 7; i++) begin
            csr_addr = addrList[i]; #1;
            compared++; if (csr_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_csr_%h: got %h want 0", addrList[i], csr_rdata); end
        end
    endtask

    task automatic test_csr_access();
        doReset();
        for (int i = 0; i < 60; i++) begin
            csr_addr  = ($urandom_range(0, 4) == 0) ? 12'($urandom) : addrList[$urandom_range(0, 6)];
            csr_op    = 2'($urandom_range(0, 3));
            csr_wdata = $urandom;
            #1;
            compared++; if (csr_rdata !== modelRead(csr_addr)) begin mismatched++; $display("[TB] FAIL csr_read_%h: got %h want %h", csr_addr, csr_rdata, modelRead(csr_addr)); end
            tick();
        end
        csr_op = 2'b00;
    endtask

    task automatic test_ext_trap();
        doReset();
        csrWrite(12'h300, 32'h8);
        csrWrite(12'h304, 32'h800);
        csrWrite(12'h305, 32'h100);
        ext_irq = 1'b1; pc_ex = 32'h40; #1;
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("[TB] FAIL ext_irq_early: got %0b want 0", interrupt); end
        tick(); #1;
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("[TB] FAIL ext_interrupt: got %0b want 1", interrupt); end
        tick(); ext_irq = 1'b0; #1;
        compared++; if (epc_taken !== 1'b1) begin mismatched++; $display("[TB] FAIL ext_epc_taken: got %0b want 1", epc_taken); end
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("[TB] FAIL ext_redirect_int: got %0b want 0", interrupt); end
        compared++; if (epc !== 32'h100) begin mismatched++; $display("[TB] FAIL ext_epc: got %h want 00000100", epc); end
        csr_addr = 12'h341; #1;
        compared++; if (csr_rdata !== 32'h40) begin mismatched++; $display("[TB] FAIL ext_mepc: got %h want 00000040", csr_rdata); end
        csr_addr = 12'h342; #1;
        compared++; if (csr_rdata !== 32'h8000_000B) begin mismatched++; $display("[TB] FAIL ext_mcause: got %h want 8000000b", csr_rdata); end
        csr_addr = 12'h300; #1;
        compared++; if (csr_rdata !== 32'h80) begin mismatched++; $display("[TB] FAIL ext_mstatus: got %h want 00000080", csr_rdata); end
        tick();
        is_mret = 1'b1; #1;
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("[TB] FAIL mret_no_int: got %0b want 0", interrupt); end
        tick(); is_mret = 1'b0; #1;
        compared++; if (epc_taken !== 1'b1) begin mismatched++; $display("[TB] FAIL mret_epc_taken: got %0b want 1", epc_taken); end
        compared++; if (epc !== 32'h40) begin mismatched++; $display("[TB] FAIL mret_epc: got %h want 00000040", epc); end
        compared++; if (csr_rdata !== 32'h88) begin mismatched++; $display("[TB] FAIL mret_mstatus: got %h want 00000088", csr_rdata); end
        tick(); #1;
        compared++; if (epc_taken !== 1'b0) begin mismatched++; $display("[TB] FAIL mret_pulse_len: got %0b want 0", epc_taken); end
    endtask

    task automatic test_priority();
        doReset();
        csrWrite(12'h300, 32'h8);
        csrWrite(12'h304, 32'h880);
        csrWrite(12'h305, 32'h200);
        timer_irq = 1'b1; ext_irq = 1'b1; pc_ex = 32'h1000;
        tick(); #1;
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_interrupt: got %0b want 1", interrupt); end
        tick(); ext_irq = 1'b0; csr_addr = 12'h342; #1;
        compared++; if (csr_rdata !== 32'h8000_000B) begin mismatched++; $display("[TB] FAIL prio_mcause_ext: got %h want 8000000b", csr_rdata); end
        tick();
        is_mret = 1'b1; #1;
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_masked: got %0b want 0", interrupt); end
        tick(); is_mret = 1'b0; #1;
        compared++; if (interrupt !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_redirect_int: got %0b want 0", interrupt); end
        tick(); #1;
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_timer_int: got %0b want 1", interrupt); end
        tick(); timer_irq = 1'b0; #1;
        compared++; if (csr_rdata !== 32'h8000_0007) begin mismatched++; $display("[TB] FAIL prio_mcause_timer: got %h want 80000007", csr_rdata); end
        tick();
    endtask

    task automatic test_mret_collision();
        doReset();
        csrWrite(12'h300, 32'h8);
        csrWrite(12'h304, 32'h800);
        csrWrite(12'h305, 32'h100);
        ext_irq = 1'b1;
        tick();
        is_mret = 1'b1; pc_ex = 32'h80;
        csr_addr = 12'h305; csr_op = 2'b01; csr_wdata = 32'hDEAD_0000; #1;
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("[TB] FAIL coll_interrupt: got %0b want 1", interrupt); end
        tick(); is_mret = 1'b0; csr_op = 2'b00; ext_irq = 1'b0; #1;
        compared++; if (epc !== 32'h100) begin mismatched++; $display("[TB] FAIL coll_epc: got %h want 00000100", epc); end
        compared++; if (csr_rdata !== 32'h100) begin mismatched++; $display("[TB] FAIL coll_flush_mtvec: got %h want 00000100", csr_rdata); end
        csr_addr = 12'h341; #1;
        compared++; if (csr_rdata !== 32'h80) begin mismatched++; $display("[TB] FAIL coll_mepc: got %h want 00000080", csr_rdata); end
        csr_addr = 12'h300; #1;
        compared++; if (csr_rdata !== 32'h80) begin mismatched++; $display("[TB] FAIL coll_mstatus: got %h want 00000080", csr_rdata); end
        tick();
    endtask

    task automatic test_vector();
        logic [31:0] expMtvec, expEpc;
`ifdef CSR_VECTORED_EN
        expMtvec = 32'h101; expEpc = 32'h11C;
`else
        expMtvec = 32'h100; expEpc = 32'h100;
`endif
        doReset();
        csrWrite(12'h305, 32'h101);
        csrWrite(12'h300, 32'h8);
        csrWrite(12'h304, 32'h80);
        csr_addr = 12'h305; #1;
        compared++; if (csr_rdata !== expMtvec) begin mismatched++; $display("[TB] FAIL vec_mtvec: got %h want %h", csr_rdata, expMtvec); end
        timer_irq = 1'b1;
        tick(); #1;
        compared++; if (interrupt !== 1'b1) begin mismatched++; $display("[TB] FAIL vec_interrupt: got %0b want 1", interrupt); end
        tick(); timer_irq = 1'b0; #1;
        compared++; if (epc !== expEpc) begin mismatched++; $display("[TB] FAIL vec_epc: got %h want %h", epc, expEpc); end
        tick();
    endtask

    task automatic test_reset_in_redirect();
        doReset();
        csrWrite(12'h300, 32'h8);
        csrWrite(12'h304, 32'h800);
        csrWrite(12'h305, 32'h300);
        csrWrite(12'h341, 32'h44);
        ext_irq = 1'b1; pc_ex = 32'h64;
        tick();
        tick(); #1;
        compared++; if (epc_taken !== 1'b1) begin mismatched++; $display("[TB] FAIL rstred_taken: got %0b want 1", epc_taken); end
        rst = 1'b1; ext_irq = 1'b0;
        tick(); rst = 1'b0; #1;
        compared++; if (epc_taken !== 1'b0) begin mismatched++; $display("[TB] FAIL rstred_abort: got %0b want 0", epc_taken); end
        compared++; if (epc !== 32'h0) begin mismatched++; $display("[TB] FAIL rstred_epc: got %h want 0", epc); end
        for (int i = 0; i < 7; i++) begin
            csr_addr = addrList[i]; #1;
            compared++; if (csr_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rstred_csr_%h: got %h want 0", addrList[i], csr_rdata); end
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            csr_addr  = addrList[$urandom_range(0, 6)];
            csr_op    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            csr_wdata = ($urandom_range(0, 1) == 0) ? 32'h888 : $urandom;
            is_mret   = (csr_op == 2'b00) && ($urandom_range(0, 5) == 0);
            pc_ex     = $urandom;
            if ($urandom_range(0, 5) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
            #1;
            compared++; if (interrupt !== (!refRedirect && modelPending())) begin mismatched++; $display("[TB] FAIL rnd_interrupt@%0d: got %0b want %0b", i, interrupt, !refRedirect && modelPending()); end
            compared++; if (epc_taken !== refRedirect) begin mismatched++; $display("[TB] FAIL rnd_epc_taken@%0d: got %0b want %0b", i, epc_taken, refRedirect); end
            compared++; if (epc !== refEpc) begin mismatched++; $display("[TB] FAIL rnd_epc@%0d: got %h want %h", i, epc, refEpc); end
            compared++; if (csr_rdata !== modelRead(csr_addr)) begin mismatched++; $display("[TB] FAIL rnd_rdata_%h@%0d: got %h want %h", csr_addr, i, csr_rdata, modelRead(csr_addr)); end
            tick();
        end
        rst = 1'b0;
        idleInputs();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        refMstatus = 0; refMie = 0; refMtvec = 0; refMepc = 0;
        refMcause = 0; refMip = 0; refEpc = 0; refRedirect = 0;
        rst = 1'b1;
        idleInputs();
        test_reset();
        test_csr_access();
        test_ext_trap();
        test_priority();
        test_mret_collision();
        test_vector();
        test_reset_in_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
